// File: rtl/obzpu_bank_if.sv
// obzpu_bank_if: bus bundle between core logic and the obzpu_bank pad bank.
//
// Signals:
//   d     core -> bank   data to drive (WIDTH bits)
//   t     core -> bank   tristate request (1 = release, 0 = request drive)
//   gts   core -> bank   global tristate, forces pads off combinationally
//   o     bank -> pads   resolved pad value (strong data or weak level)
//   oe    bank -> core   drivers enabled
//   busy  bank -> core   bank is in a turnaround dead-time state
//
// Modports: master (core side) and slave (the bank itself).
interface obzpu_bank_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d;
    logic             t;
    logic             gts;
    logic [WIDTH-1:0] o;
    logic             oe;
    logic             busy;

    modport master (
        output d, t, gts,
        input  o, oe, busy
    );

    modport slave (
        input  d, t, gts,
        output o, oe, busy
    );
endinterface

// File: rtl/obzpu_bank.sv
// obzpu_bank: registered multi-bit tristate output bank with a weak level on
// every released pad and a programmable bus-turnaround dead time.
//
// Parameters:
//   WIDTH  number of pad channels (1..64)
//   DEAD   dead-time cycles before driving and after releasing (0..15)
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst    asynchronous active-high reset; releases the pads at once
//   bus    obzpu_bank_if.slave: d, t, gts in; o, oe, busy out
//
// Optional feature: define OBZPU_BANK_KEEPER_EN to replace the weak pull-up
// with a weak bus keeper that holds the last driven value on released pads.
//
// o is the resolved pad value as seen by the core: the registered data when
// the drivers are enabled, otherwise the weak level (pull-up or keeper).
module obzpu_bank #(
    parameter int WIDTH = 8,
    parameter int DEAD  = 2
) (
    input  logic         clk,
    input  logic         rst,
    obzpu_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        HIZ     = 2'd0,
        ARM     = 2'd1,
        DRIVE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam bit         DEAD_ZERO = (DEAD == 0);
    localparam logic [3:0] DEAD_M1   = (DEAD == 0) ? 4'd0 : 4'(DEAD - 1);

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [WIDTH-1:0] dq_reg;
    logic [WIDTH-1:0] weak_val;
    logic             start_req;
    logic             stop_req;
    logic             drive_en;

    assign start_req = !bus.t && !bus.gts;
    assign stop_req  = bus.t || bus.gts;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HIZ;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            HIZ: begin
                if (start_req) begin
                    if (DEAD_ZERO) begin
                        state_next = DRIVE;
                    end else begin
                        state_next = ARM;
                        cnt_next   = DEAD_M1;
                    end
                end
            end
            ARM: begin
                if (stop_req) begin
                    state_next = HIZ;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == 4'd0) begin
                    state_next = DRIVE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DRIVE: begin
                // t and gts together still produce a single release.
                if (stop_req) begin
                    if (DEAD_ZERO) begin
                        state_next = HIZ;
                    end else begin
                        state_next = RELEASE;
                        cnt_next   = DEAD_M1;
                    end
                end
            end
            RELEASE: begin
                // t/gts are ignored while counting down. On the final edge the
                // bank is back in Hi-Z, and that same edge is also treated as a
                // Hi-Z sample, so an already pending drive request enters ARM
                // directly. This gives the earliest re-drive at m + 2*DEAD
                // while keeping the Hi-Z gap at least DEAD cycles.
                if (cnt_reg == 4'd0) begin
                    if (start_req) begin
                        state_next = ARM;
                        cnt_next   = DEAD_M1;
                    end else begin
                        state_next = HIZ;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = HIZ;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data register: loads every edge, independent of state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_reg <= '0;
        end else begin
            dq_reg <= bus.d;
        end
    end

    // ------------------------------------------------------------------
    // Weak level on released pads
    // ------------------------------------------------------------------
`ifdef OBZPU_BANK_KEEPER_EN
    logic [WIDTH-1:0] kq_reg;

    // Keeper tracks what is being driven; all-ones after reset so the
    // released pad reads the same as in pull-up mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kq_reg <= '1;
        end else if (state_reg == DRIVE) begin
            kq_reg <= dq_reg;
        end
    end

    assign weak_val = kq_reg;
`else
    assign weak_val = '1;
`endif

    // ------------------------------------------------------------------
    // Outputs. gts gates the registered enable combinationally so the
    // drivers drop in the same cycle gts rises; reset clears state_reg
    // asynchronously with the same effect.
    // ------------------------------------------------------------------
    assign drive_en = (state_reg == DRIVE) && !bus.gts;
    assign bus.oe   = drive_en;
    assign bus.busy = (state_reg == ARM) || (state_reg == RELEASE);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pad
        assign bus.o[gi] = drive_en ? dq_reg[gi] : weak_val[gi];
    end

endmodule

// File: tb/tb_obzpu_bank.sv
// tb_obzpu_bank: self-checking bench for obzpu_bank (pull-up build).
// Two instances: DEAD=2 (main timing checks) and DEAD=0 (direct drive).
// Each step drives inputs on the falling edge, pushes the expected post-edge
// outputs to a scoreboard queue, and pops/compares after the rising edge.
module tb_obzpu_bank;

    logic clk;
    logic rst_a;
    logic rst_b;

    obzpu_bank_if #(.WIDTH(8)) bus_a ();
    obzpu_bank_if #(.WIDTH(8)) bus_b ();

    obzpu_bank #(.WIDTH(8), .DEAD(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    obzpu_bank #(.WIDTH(8), .DEAD(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         sel;
        logic       oe;
        logic       busy;
        logic [7:0] o;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   step_idx = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock transaction on the selected instance.
    task automatic step(input bit sel, input logic t, input logic gts, input logic [7:0] d,
                        input logic eoe, input logic ebusy, input logic [7:0] eo);
        exp_t e;
        exp_t got_e;
        @(negedge clk);
        if (sel) begin
            bus_b.t = t; bus_b.gts = gts; bus_b.d = d;
        end else begin
            bus_a.t = t; bus_a.gts = gts; bus_a.d = d;
        end
        e.sel = sel; e.oe = eoe; e.busy = ebusy; e.o = eo;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb_q.pop_front();
        if (got_e.sel) begin
            check($sformatf("s%0d_b_oe", step_idx), 64'(bus_b.oe), 64'(got_e.oe));
            check($sformatf("s%0d_b_busy", step_idx), 64'(bus_b.busy), 64'(got_e.busy));
            check($sformatf("s%0d_b_o", step_idx), 64'(bus_b.o), 64'(got_e.o));
            $display("[TB] step %0d dut_b t=%b gts=%b d=%h -> oe=%b busy=%b o=%h",
                     step_idx, t, gts, d, bus_b.oe, bus_b.busy, bus_b.o);
        end else begin
            check($sformatf("s%0d_a_oe", step_idx), 64'(bus_a.oe), 64'(got_e.oe));
            check($sformatf("s%0d_a_busy", step_idx), 64'(bus_a.busy), 64'(got_e.busy));
            check($sformatf("s%0d_a_o", step_idx), 64'(bus_a.o), 64'(got_e.o));
            $display("[TB] step %0d dut_a t=%b gts=%b d=%h -> oe=%b busy=%b o=%h",
                     step_idx, t, gts, d, bus_a.oe, bus_a.busy, bus_a.o);
        end
        step_idx++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.t = 1'b0; bus_a.gts = 1'b0; bus_a.d = 8'h00;
        bus_b.t = 1'b1; bus_b.gts = 1'b0; bus_b.d = 8'h00;

        // Reset state: weak-high, drivers off, not busy (even with t=0).
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_o", 64'(bus_a.o), 64'h0FF);
        check("rst_a_oe", 64'(bus_a.oe), 64'h0);
        check("rst_a_busy", 64'(bus_a.busy), 64'h0);
        check("rst_b_o", 64'(bus_b.o), 64'h0FF);

        @(negedge clk);
        bus_a.t = 1'b1;
        rst_a = 1'b0; rst_b = 1'b0;

        // DEAD=2: first edge with t=0 is edge 0; OE at edge 2.
        step(0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'hFF);
        step(0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'hFF);   // edge 0: ARM
        step(0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 8'hFF);   // edge 1
        step(0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'h11);   // edge 2: DRIVE
        // Data path, one edge latency.
        step(0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5);
        step(0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C);
        // Release at m, t=0 at m+1 ignored, ARM at m+2, OE at m+4.
        step(0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 8'hFF);   // m
        step(0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'hFF);   // m+1
        step(0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'hFF);   // m+2: ARM
        step(0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'hFF);   // m+3
        step(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);   // m+4: DRIVE 00

        // GTS mid-cycle while driving 00: pads off before the next edge.
        #2;
        bus_a.gts = 1'b1;
        #1;
        check("gts_async_o", 64'(bus_a.o), 64'h0FF);
        check("gts_async_oe", 64'(bus_a.oe), 64'h0);
        step(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hFF);   // RELEASE
        step(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hFF);
        step(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF);   // HIZ (gts held)
        step(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF);
        // GTS during ARM aborts; T during ARM aborts.
        step(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF);   // ARM
        step(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF);   // abort -> HIZ
        step(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF);
        step(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF);   // ARM
        step(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF);   // abort -> HIZ
        // Drive again then async reset mid-DRIVE.
        step(0, 1'b0, 1'b0, 8'h42, 1'b0, 1'b1, 8'hFF);
        step(0, 1'b0, 1'b0, 8'h42, 1'b0, 1'b1, 8'hFF);
        step(0, 1'b0, 1'b0, 8'h42, 1'b1, 1'b0, 8'h42);
        #2;
        rst_a = 1'b1;
        #1;
        check("rst_mid_oe", 64'(bus_a.oe), 64'h0);
        check("rst_mid_o", 64'(bus_a.o), 64'h0FF);
        check("rst_mid_busy", 64'(bus_a.busy), 64'h0);
        step(0, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0, 8'hFF);   // held in reset
        #2;
        rst_a = 1'b0;
        step(0, 1'b0, 1'b0, 8'h42, 1'b0, 1'b1, 8'hFF);   // first t=0 edge: ARM

        // DEAD=0: OE follows !t with one-edge delay, never busy.
        step(1, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 8'h77);
        step(1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 8'hFF);
        step(1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h5A);
        step(1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'hFF);
        step(1, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 8'h77);
        #2;
        rst_b = 1'b1;
        #1;
        check("rst0_mid_oe", 64'(bus_b.oe), 64'h0);
        check("rst0_mid_o", 64'(bus_b.o), 64'h0FF);
        step(1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 8'hFF);
        #2;
        rst_b = 1'b0;
        step(1, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 8'h77);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
